// File: rtl/tdc_gpx2_frame_decoder_pkg.sv
// GPX2 result-word constants and layout helpers shared by the frame decoder, the DAQ buffer and software.
// Also holds the per-bit framing step that the decoder unrolls across one deserializer beat.
package tdc_gpx2_pkg;

    localparam int GPX2_DES_WIDTH  = 8;
    localparam int GPX2_WORD_BITS  = 22;
    localparam int GPX2_STOP_BITS  = 16;
    localparam int GPX2_REFID_BITS = GPX2_WORD_BITS - GPX2_STOP_BITS;

    // Sized for any supported WORD_BITS; the decoder only uses the low WORD_BITS.
    localparam int MAX_WORD_BITS = 64;
    localparam int CNT_W         = 8;
    localparam int ERR_INC_W     = 8;

    typedef logic [GPX2_WORD_BITS-1:0]  gpx2_word_t;
    typedef logic [GPX2_REFID_BITS-1:0] gpx2_refid_t;
    typedef logic [GPX2_STOP_BITS-1:0]  gpx2_stop_t;

    typedef struct packed {
        logic [MAX_WORD_BITS-1:0] shreg;
        logic [CNT_W-1:0]         bit_cnt;
        logic                     done;
        logic [MAX_WORD_BITS-1:0] word;
        logic [ERR_INC_W-1:0]     err_inc;
    } step_t;

    function automatic gpx2_refid_t gpx2_refid(input gpx2_word_t word);
        return word[GPX2_WORD_BITS-1 -: GPX2_REFID_BITS];
    endfunction

    function automatic gpx2_stop_t gpx2_stop(input gpx2_word_t word);
        return word[GPX2_STOP_BITS-1:0];
    endfunction

    // One serial bit: a frame bit always opens a new word, aborting (and counting) any open one.
    function automatic step_t gpx2_bit_step(input step_t cur, input logic sdo, input logic frame,
                                            input logic [CNT_W-1:0] last_cnt);
        step_t nxt;
        nxt = cur;
        if (frame) begin
            if (cur.bit_cnt != {CNT_W{1'b0}}) begin
                nxt.err_inc = cur.err_inc + ERR_INC_W'(1);
            end else begin
                nxt.err_inc = cur.err_inc;
            end
            nxt.shreg   = {{(MAX_WORD_BITS-1){1'b0}}, sdo};
            nxt.bit_cnt = last_cnt;
        end else if (cur.bit_cnt != {CNT_W{1'b0}}) begin
            nxt.shreg   = {cur.shreg[MAX_WORD_BITS-2:0], sdo};
            nxt.bit_cnt = cur.bit_cnt - CNT_W'(1);
            if (cur.bit_cnt == CNT_W'(1)) begin
                nxt.done = 1'b1;
                nxt.word = nxt.shreg;
            end else begin
                nxt.done = cur.done;
            end
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/tdc_gpx2_frame_decoder_if.sv
// Bundle between the ISERDES side of one GPX2 stop channel and the DAQ buffer side.
interface tdc_gpx2_frame_decoder_if #(
    parameter int DES_WIDTH     = 8,
    parameter int WORD_BITS     = 22,
    parameter int ERR_CNT_WIDTH = 8
);
    logic                     enable_i;
    logic [DES_WIDTH-1:0]     sdo_i;
    logic [DES_WIDTH-1:0]     frame_i;
    logic [WORD_BITS-1:0]     data_o;
    logic                     data_stb_o;
    logic                     busy_o;
    logic [ERR_CNT_WIDTH-1:0] frame_err_cnt_o;

    modport master (
        output enable_i, sdo_i, frame_i,
        input  data_o, data_stb_o, busy_o, frame_err_cnt_o
    );

    modport slave (
        input  enable_i, sdo_i, frame_i,
        output data_o, data_stb_o, busy_o, frame_err_cnt_o
    );
endinterface

// File: rtl/tdc_gpx2_frame_decoder.sv
// Aligns on GPX2 FRAME and assembles WORD_BITS-bit result words from a DES_WIDTH-wide
// deserialized SDO stream; one word strobe at most per dclk cycle.
module tdc_gpx2_frame_decoder
    import tdc_gpx2_pkg::*;
#(
    parameter int DES_WIDTH     = GPX2_DES_WIDTH,
    parameter int WORD_BITS     = GPX2_WORD_BITS,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                    dclk_clk,
    input  logic                    dclk_rst_n,
    tdc_gpx2_frame_decoder_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_BITS - 1);
    localparam logic [31:0]      ERR_MAX  = (32'd1 << ERR_CNT_WIDTH) - 32'd1;

    logic [MAX_WORD_BITS-1:0] shreg_r;
    logic [CNT_W-1:0]         bit_cnt_r;
    logic [WORD_BITS-1:0]     data_r;
    logic                     data_stb_r;
    logic                     busy_r;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_r;

    step_t                    st_s;
    logic [31:0]              err_sum_s;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_nxt_s;
    logic                     unused_word_hi_s;

    // Walk the beat MSB (earliest) to LSB through the per-bit framing step.
    always_comb begin
        st_s.shreg   = shreg_r;
        st_s.bit_cnt = bit_cnt_r;
        st_s.done    = 1'b0;
        st_s.word    = {MAX_WORD_BITS{1'b0}};
        st_s.err_inc = {ERR_INC_W{1'b0}};
        if (bus.enable_i) begin
            for (int i = DES_WIDTH - 1; i >= 0; i--) begin
                st_s = gpx2_bit_step(st_s, bus.sdo_i[i], bus.frame_i[i], LAST_CNT);
            end
        end else begin
            st_s.bit_cnt = {CNT_W{1'b0}};
        end
    end

    // Saturating accumulation of the aborted-word count for this beat.
    always_comb begin
        err_sum_s = 32'(err_cnt_r) + 32'(st_s.err_inc);
        if (err_sum_s > ERR_MAX) begin
            err_cnt_nxt_s = {ERR_CNT_WIDTH{1'b1}};
        end else begin
            err_cnt_nxt_s = err_sum_s[ERR_CNT_WIDTH-1:0];
        end
    end

    // Single register stage for collector state and all outputs.
    always_ff @(posedge dclk_clk) begin
        if (!dclk_rst_n) begin
            shreg_r    <= {MAX_WORD_BITS{1'b0}};
            bit_cnt_r  <= {CNT_W{1'b0}};
            data_r     <= {WORD_BITS{1'b0}};
            data_stb_r <= 1'b0;
            busy_r     <= 1'b0;
            err_cnt_r  <= {ERR_CNT_WIDTH{1'b0}};
        end else begin
            shreg_r    <= st_s.shreg;
            bit_cnt_r  <= st_s.bit_cnt;
            data_stb_r <= st_s.done;
            busy_r     <= (st_s.bit_cnt != {CNT_W{1'b0}});
            err_cnt_r  <= err_cnt_nxt_s;
            if (st_s.done) begin
                data_r <= st_s.word[WORD_BITS-1:0];
            end else begin
                data_r <= data_r;
            end
        end
    end

    assign unused_word_hi_s    = ^st_s.word[MAX_WORD_BITS-1:WORD_BITS];

    assign bus.data_o          = data_r;
    assign bus.data_stb_o      = data_stb_r;
    assign bus.busy_o          = busy_r;
    assign bus.frame_err_cnt_o = err_cnt_r;

endmodule

// File: tb/tb_tdc_gpx2_frame_decoder.sv
// Scoreboard bench for tdc_gpx2_frame_decoder: a bit-queue reference model predicts each cycle,
// a negedge monitor checks strobed words and per-cycle status.
module tb_tdc_gpx2_frame_decoder;

    localparam int DW = 8;
    localparam int WB = 22;
    localparam int EW = 8;
    localparam int ERR_SAT = (1 << EW) - 1;

    typedef struct {
        logic [WB-1:0] word;
        int            due;
    } wexp_t;

    typedef struct {
        logic          stb;
        logic [WB-1:0] data;
        logic [EW-1:0] err;
        logic          busy;
        int            due;
    } sexp_t;

    logic dclk_clk   = 1'b0;
    logic dclk_rst_n = 1'b0;
    always #5 dclk_clk = ~dclk_clk;

    tdc_gpx2_frame_decoder_if #(.DES_WIDTH(DW), .WORD_BITS(WB), .ERR_CNT_WIDTH(EW)) bus ();

    tdc_gpx2_frame_decoder #(.DES_WIDTH(DW), .WORD_BITS(WB), .ERR_CNT_WIDTH(EW)) dut (
        .dclk_clk   (dclk_clk),
        .dclk_rst_n (dclk_rst_n),
        .bus        (bus)
    );

    int    cyc = 0;
    int    nchecks = 0;
    int    nerrs = 0;
    wexp_t word_q[$];
    sexp_t stat_q[$];

    // Reference model state: bits of the word being collected, last word, error count.
    bit            m_bits[$];
    logic [WB-1:0] m_data = '0;
    int            m_err = 0;

    // Pending serial stream (time order) for the stream-based stimulus.
    bit s_sdo[$];
    bit s_frm[$];

    always @(posedge dclk_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_cycle(input logic [DW-1:0] s, input logic [DW-1:0] f, input logic en, input logic rst_n);
        sexp_t e;
        wexp_t w;
        logic [WB-1:0] v;
        e.stb = 1'b0;
        if (!rst_n) begin
            m_bits.delete();
            m_err  = 0;
            m_data = '0;
        end else if (!en) begin
            m_bits.delete();
        end else begin
            for (int i = DW - 1; i >= 0; i--) begin
                if (f[i]) begin
                    if (m_bits.size() > 0) m_err = (m_err < ERR_SAT) ? m_err + 1 : ERR_SAT;
                    m_bits.delete();
                    m_bits.push_back(s[i]);
                end else if (m_bits.size() > 0) begin
                    m_bits.push_back(s[i]);
                end
                if (m_bits.size() == WB) begin
                    v = '0;
                    foreach (m_bits[j]) v = {v[WB-2:0], m_bits[j]};
                    m_data = v;
                    e.stb  = 1'b1;
                    w.word = v;
                    w.due  = cyc + 1;
                    word_q.push_back(w);
                    m_bits.delete();
                end
            end
        end
        e.data = m_data;
        e.err  = EW'(m_err);
        e.busy = (m_bits.size() > 0);
        e.due  = cyc + 1;
        stat_q.push_back(e);
    endtask

    task automatic drive_cycle(input logic [DW-1:0] s, input logic [DW-1:0] f, input logic en, input logic rst_n);
        bus.sdo_i    = s;
        bus.frame_i  = f;
        bus.enable_i = en;
        dclk_rst_n   = rst_n;
        model_cycle(s, f, en, rst_n);
        @(posedge dclk_clk);
        #1;
    endtask

    task automatic push_idle(input int n);
        for (int j = 0; j < n; j++) begin
            s_sdo.push_back(1'($urandom_range(0, 1)));
            s_frm.push_back(1'b0);
        end
    endtask

    // First n bits of v, MSB first, with the frame marker on the first bit.
    task automatic push_word(input logic [WB-1:0] v, input int n);
        for (int j = 0; j < n; j++) begin
            s_sdo.push_back(v[WB-1-j]);
            s_frm.push_back(j == 0);
        end
    endtask

    task automatic take_beat(output logic [DW-1:0] s, output logic [DW-1:0] f);
        for (int i = DW - 1; i >= 0; i--) begin
            if (s_sdo.size() > 0) begin
                s[i] = s_sdo.pop_front();
                f[i] = s_frm.pop_front();
            end else begin
                s[i] = 1'($urandom_range(0, 1));
                f[i] = 1'b0;
            end
        end
    endtask

    task automatic flush();
        logic [DW-1:0] s;
        logic [DW-1:0] f;
        while (s_sdo.size() > 0) begin
            take_beat(s, f);
            drive_cycle(s, f, 1'b1, 1'b1);
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) drive_cycle(DW'($urandom), '0, 1'b1, 1'b1);
    endtask

    // Monitor: compare each strobed word, then the per-cycle status due now.
    always @(negedge dclk_clk) begin
        wexp_t w;
        sexp_t e;
        if (bus.data_stb_o === 1'b1) begin
            if (word_q.size() == 0) begin
                chk("spurious_strobe", 64'(bus.data_o), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                w = word_q.pop_front();
                chk("strobe_word", 64'(bus.data_o), 64'(w.word));
                chk("strobe_latency", 64'(cyc), 64'(w.due));
            end
        end
        while (stat_q.size() > 0 && stat_q[0].due <= cyc) begin
            e = stat_q.pop_front();
            chk("data_stb", 64'(bus.data_stb_o), 64'(e.stb));
            chk("data", 64'(bus.data_o), 64'(e.data));
            chk("err_cnt", 64'(bus.frame_err_cnt_o), 64'(e.err));
            chk("busy", 64'(bus.busy_o), 64'(e.busy));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] s;
        logic [DW-1:0] f;
        logic [WB-1:0] v1;
        int kind;

        bus.sdo_i    = '0;
        bus.frame_i  = '0;
        bus.enable_i = 1'b0;
        @(posedge dclk_clk);
        #1;
        drive_cycle('0, '0, 1'b1, 1'b0);
        drive_cycle('0, '0, 1'b1, 1'b0);
        idle(1);

        // Aligned word
        drive_cycle(8'hE9, 8'h80, 1'b1, 1'b1);
        drive_cycle(8'h70, 8'h00, 1'b1, 1'b1);
        drive_cycle(8'hFC, 8'h00, 1'b1, 1'b1);
        idle(2);
        chk("aligned_word", 64'(bus.data_o), 64'h3A5C3F);
        chk("aligned_busy", 64'(bus.busy_o), 64'd0);

        // Unaligned word: frame at byte0[3]
        push_idle(4);
        push_word(22'h155555, WB);
        flush();
        idle(2);
        chk("unaligned_word", 64'(bus.data_o), 64'h155555);

        // Back-to-back words, second frame at byte3[5]
        push_idle(4);
        push_word(22'h155555, WB);
        push_word(22'h0ABCDE, WB);
        flush();
        idle(2);
        chk("b2b_word", 64'(bus.data_o), 64'h0ABCDE);
        chk("b2b_err", 64'(bus.frame_err_cnt_o), 64'd0);

        // Framing error: new frame at byte1[4]
        push_word(WB'($urandom), 11);
        push_word(22'h2DEAD5, WB);
        flush();
        idle(2);
        chk("ferr_cnt", 64'(bus.frame_err_cnt_o), 64'd1);
        chk("ferr_word", 64'(bus.data_o), 64'h2DEAD5);

        // Saturation: every bit a frame bit
        for (int j = 0; j < 43; j++) drive_cycle(DW'($urandom), 8'hFF, 1'b1, 1'b1);
        idle(4);
        chk("err_saturated", 64'(bus.frame_err_cnt_o), 64'd255);

        // Reset during byte 1 of a word
        push_word(WB'($urandom), WB);
        take_beat(s, f);
        drive_cycle(s, f, 1'b1, 1'b1);
        take_beat(s, f);
        drive_cycle(s, f, 1'b1, 1'b0);
        flush();
        idle(3);
        chk("rst_data", 64'(bus.data_o), 64'd0);
        chk("rst_err", 64'(bus.frame_err_cnt_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);

        // Disable during byte 1 of a word
        v1 = 22'h3C0F0A;
        push_word(v1, WB);
        flush();
        idle(1);
        push_word(WB'($urandom), WB);
        take_beat(s, f);
        drive_cycle(s, f, 1'b1, 1'b1);
        take_beat(s, f);
        drive_cycle(s, f, 1'b0, 1'b1);
        flush();
        idle(3);
        chk("dis_data", 64'(bus.data_o), 64'(v1));
        chk("dis_err", 64'(bus.frame_err_cnt_o), 64'd0);

        // Randomized mix of clean words, truncated words and raw beats
        for (int it = 0; it < 80; it++) begin
            kind = $urandom_range(0, 9);
            if (kind < 6) begin
                push_idle($urandom_range(0, 12));
                push_word(WB'($urandom), WB);
            end else if (kind < 8) begin
                push_word(WB'($urandom), $urandom_range(1, WB - 1));
            end else begin
                flush();
                for (int j = 0; j < 4; j++) begin
                    f = DW'($urandom) & DW'($urandom) & DW'($urandom);
                    drive_cycle(DW'($urandom), f, ($urandom_range(0, 7) != 0), ($urandom_range(0, 20) != 0));
                end
            end
        end
        flush();
        idle(3);
        @(negedge dclk_clk);
        #1;
        chk("words_drained", 64'(word_q.size()), 64'd0);
        chk("status_drained", 64'(stat_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule
